// File: rtl/mem_port_arbiter.sv
// Shares one 32-bit memory port between instruction fetch (read-only) and the memory stage.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise ME_PRIORITY selects a fixed winner.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter bit          ME_PRIORITY = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [31:0]       if_data_o,
  output logic              if_busy_o,
  output logic              if_done_o,
  input  logic              me_r_enable_i,
  input  logic              me_w_enable_i,
  input  logic [3:0]        me_w_mask_i,
  input  logic [31:0]       me_w_data_i,
  input  logic [ADDR_W-1:0] me_addr_i,
  output logic [31:0]       me_r_data_o,
  output logic              me_busy_o,
  output logic              me_done_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_mask_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_e;

  state_e            state_q;
  logic              owner_me_q;
  logic              busy_q;
  logic              mem_req_q;
  logic              we_q;
  logic [3:0]        mask_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       if_data_q;
  logic [31:0]       me_data_q;
  logic              if_done_q;
  logic              me_done_q;
`ifdef MEM_ARB_RR_EN
  logic              last_me_q;
`endif

  logic              me_req;
  logic              grant_me;
  logic              grant_we;
  logic [ADDR_W-1:0] grant_addr;
  logic              rv_fire;

  // Arbitration and response qualification
  always_comb begin
    me_req = me_r_enable_i | me_w_enable_i;
`ifdef MEM_ARB_RR_EN
    grant_me = me_req & (~if_req_i | ~last_me_q);
`else
    grant_me = me_req & (~if_req_i | ME_PRIORITY);
`endif
    grant_we   = grant_me & me_w_enable_i;
    grant_addr = grant_me ? me_addr_i : if_addr_i;
    // rvalid counts only once the request has been accepted
    rv_fire    = mem_rvalid_i & ((state_q == S_RESP) | ((state_q == S_REQ) & mem_ack_i));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      owner_me_q <= 1'b0;
      busy_q     <= 1'b0;
      mem_req_q  <= 1'b0;
      we_q       <= 1'b0;
      mask_q     <= 4'b0000;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      if_data_q  <= 32'h0;
      me_data_q  <= 32'h0;
      if_done_q  <= 1'b0;
      me_done_q  <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_me_q  <= 1'b0;
`endif
    end else begin
      if_done_q <= 1'b0;
      me_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (if_req_i | me_req) begin
            owner_me_q <= grant_me;
            we_q       <= grant_we;
            mask_q     <= grant_we ? me_w_mask_i : 4'b0000;
            wdata_q    <= grant_we ? me_w_data_i : 32'h0;
            addr_q     <= {grant_addr[ADDR_W-1:2], 2'b00};
            mem_req_q  <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_ack_i) begin
            mem_req_q <= 1'b0;
            state_q   <= S_RESP;
          end
        end
        S_RESP: ;
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
`ifdef MEM_ARB_RR_EN
          last_me_q <= owner_me_q;
`endif
        end
        default: state_q <= S_IDLE;
      endcase

      // Completion overrides the REQ->RESP step when ack and rvalid coincide
      if (rv_fire) begin
        state_q   <= S_DONE;
        if_done_q <= ~owner_me_q;
        me_done_q <= owner_me_q;
        if (!we_q) begin
          if (owner_me_q) me_data_q <= mem_rdata_i;
          else            if_data_q <= mem_rdata_i;
        end
      end
    end
  end

  assign if_data_o   = if_data_q;
  assign if_busy_o   = busy_q;
  assign if_done_o   = if_done_q;
  assign me_r_data_o = me_data_q;
  assign me_busy_o   = busy_q;
  assign me_done_o   = me_done_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = we_q;
  assign mem_mask_o  = mask_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

endmodule
